// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: records predictions at fetch, emits registered
// training strobes on resolution, and flushes wrong-path entries on a misprediction.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PCW   = 7,
  parameter int HW    = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid,
  input  logic [PCW-1:0]           enq_pc,
  input  logic [HW-1:0]            enq_history,
  input  logic                     enq_pred_taken,
  output logic                     enq_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     train_valid,
  output logic                     train_taken,
  output logic                     train_mispredicted,
  output logic [PCW-1:0]           train_pc,
  output logic [HW-1:0]            train_history,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [HW-1:0]  history;
    logic           pred_taken;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           train_valid_q, train_valid_d;
  logic           train_taken_q, train_taken_d;
  logic           train_mis_q, train_mis_d;
  logic [PCW-1:0] train_pc_q, train_pc_d;
  logic [HW-1:0]  train_hist_q, train_hist_d;
  logic           flush_q, flush_d;
  logic           underflow_q, underflow_d;

  logic   enq_fire, res_fire, mis;
  entry_t head;

  assign enq_ready = (count_q != CW'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready;
  assign res_fire  = res_valid && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign mis       = res_taken ^ head.pred_taken;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    train_valid_d = 1'b0;
    train_mis_d   = 1'b0;
    flush_d       = 1'b0;
    train_taken_d = train_taken_q;
    train_pc_d    = train_pc_q;
    train_hist_d  = train_hist_q;
    underflow_d   = underflow_q;

    if (enq_fire) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end

    if (res_fire) begin
      train_valid_d = 1'b1;
      train_taken_d = res_taken;
      train_mis_d   = mis;
      train_pc_d    = head.pc;
      train_hist_d  = head.history;
      if (mis) begin
        // Everything younger than the head is wrong-path, including a same-cycle enqueue.
        wr_ptr_d = rd_ptr_q;
        count_d  = '0;
        flush_d  = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        count_d  = enq_fire ? count_q : count_q - CW'(1);
      end
    end else if (res_valid) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      train_valid_q <= 1'b0;
      train_taken_q <= 1'b0;
      train_mis_q   <= 1'b0;
      train_pc_q    <= '0;
      train_hist_q  <= '0;
      flush_q       <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      train_valid_q <= train_valid_d;
      train_taken_q <= train_taken_d;
      train_mis_q   <= train_mis_d;
      train_pc_q    <= train_pc_d;
      train_hist_q  <= train_hist_d;
      flush_q       <= flush_d;
      underflow_q   <= underflow_d;
    end
  end

  // NOTE: the entry storage has no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= '{pc: enq_pc, history: enq_history, pred_taken: enq_pred_taken};
  end

  assign train_valid        = train_valid_q;
  assign train_taken        = train_taken_q;
  assign train_mispredicted = train_mis_q;
  assign train_pc           = train_pc_q;
  assign train_history      = train_hist_q;
  assign flush              = flush_q;
  assign count              = count_q;
  assign underflow          = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int PCW   = 7;
  localparam int HW    = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enq_valid = 1'b0;
  logic [PCW-1:0] enq_pc = '0;
  logic [HW-1:0]  enq_history = '0;
  logic           enq_pred_taken = 1'b0;
  logic           enq_ready;
  logic           res_valid = 1'b0;
  logic           res_taken = 1'b0;
  logic           train_valid, train_taken, train_mispredicted, flush, underflow;
  logic [PCW-1:0] train_pc;
  logic [HW-1:0]  train_history;
  logic [3:0]     count;

  branch_resolve_queue #(.DEPTH(DEPTH), .PCW(PCW), .HW(HW)) dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_history(enq_history),
    .enq_pred_taken(enq_pred_taken), .enq_ready(enq_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .train_valid(train_valid), .train_taken(train_taken),
    .train_mispredicted(train_mispredicted), .train_pc(train_pc),
    .train_history(train_history), .flush(flush), .count(count),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [HW-1:0]  h;
    logic           p;
  } ent_t;

  ent_t           mq[$];
  logic           e_tv, e_tt, e_tm, e_fl, e_uf;
  logic [PCW-1:0] e_pc;
  logic [HW-1:0]  e_h;
  int             checks = 0;
  int             failures = 0;
  int             pc40_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_tv = 0; e_tt = 0; e_tm = 0; e_fl = 0; e_uf = 0; e_pc = '0; e_h = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mq.size()));
    check({tag, ".enq_ready"}, 32'(enq_ready), 32'(mq.size() != DEPTH));
    check({tag, ".train_valid"}, 32'(train_valid), 32'(e_tv));
    check({tag, ".flush"}, 32'(flush), 32'(e_fl));
    check({tag, ".underflow"}, 32'(underflow), 32'(e_uf));
    check({tag, ".train_pc"}, 32'(train_pc), 32'(e_pc));
    check({tag, ".train_history"}, 32'(train_history), 32'(e_h));
    check({tag, ".train_taken"}, 32'(train_taken), 32'(e_tt));
    if (e_tv) check({tag, ".train_mis"}, 32'(train_mispredicted), 32'(e_tm));
  endtask

  // One clock cycle: drive inputs, advance the model, then compare #1 after the edge.
  task automatic step(input string tag, input logic ev, input logic [PCW-1:0] pc,
                      input logic [HW-1:0] h, input logic p, input logic rv, input logic rt);
    ent_t hd;
    bit   acc;
    enq_valid = ev; enq_pc = pc; enq_history = h; enq_pred_taken = p;
    res_valid = rv; res_taken = rt;
    acc  = ev && (mq.size() != DEPTH);
    e_tv = 0; e_tm = 0; e_fl = 0;
    if (rv && mq.size() != 0) begin
      hd   = mq.pop_front();
      e_tv = 1; e_tt = rt; e_tm = rt ^ hd.p; e_pc = hd.pc; e_h = hd.h;
      if (e_tm) begin
        e_fl = 1;
        mq.delete();
        acc = 0;
      end
    end else if (rv) begin
      e_uf = 1;
    end
    if (acc) mq.push_back('{pc: pc, h: h, p: p});
    @(posedge clk);
    #1;
    if (train_valid && train_pc == 7'h40) pc40_seen++;
    check_all(tag);
  endtask

  function automatic logic head_pred();
    return (mq.size() != 0) ? mq[0].p : 1'b0;
  endfunction

  task automatic idle(input string tag);
    step(tag, 0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Basic correct prediction.
    step("t1_enq", 1, 7'h12, 7'h05, 1, 0, 0);
    step("t1_res", 0, '0, '0, 0, 1, 1);
    idle("t1_idle");

    // Misprediction on first of three, then underflow.
    step("t2_e0", 1, 7'h21, 7'h01, 0, 0, 0);
    step("t2_e1", 1, 7'h22, 7'h02, 0, 0, 0);
    step("t2_e2", 1, 7'h23, 7'h03, 1, 0, 0);
    step("t2_mis", 0, '0, '0, 0, 1, 1);
    idle("t2_flush_drop");
    step("t2_uf", 0, '0, '0, 0, 1, 0);
    idle("t2_idle");

    // Fill, drop the overflow enqueue, drain in order.
    for (int i = 0; i < DEPTH; i++)
      step("t3_fill", 1, PCW'(8'h30 + i), HW'(i), i[0], 0, 0);
    step("t3_drop", 1, 7'h7f, 7'h7f, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      step("t3_drain", 0, '0, '0, 0, 1, head_pred());
    idle("t3_idle");

    // Steady state with two entries: simultaneous enqueue and correct resolve, wrapping pointers.
    step("t4_p0", 1, 7'h50, 7'h10, 1, 0, 0);
    step("t4_p1", 1, 7'h51, 7'h11, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step("t4_flow", 1, PCW'(8'h52 + i), HW'(8'h12 + i), i[1], 1, head_pred());

    // Simultaneous enqueue of pc 0x40 with a mispredicted resolve.
    step("t5_mis", 1, 7'h40, 7'h0a, 0, 1, ~head_pred());
    step("t5_uf", 0, '0, '0, 0, 1, 1);
    idle("t5_idle");
    check("t5.pc40_absent", 32'(pc40_seen), 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++)
      step("t6_fill", 1, PCW'(8'h60 + i), HW'(i), 1, 0, 0);
    enq_valid = 0; res_valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("t6_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("t6_release");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic ev, rv, rt;
      ev = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0);
      rt = ($urandom_range(0, 9) != 0) ? head_pred() : 1'($urandom_range(0, 1));
      step("rand", ev, PCW'($urandom), HW'($urandom), 1'($urandom_range(0, 1)), rv, rt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracking queue that sits between the front end and the gshare predictor's training port. It records each prediction (PC, global history snapshot, predicted direction) at fetch time. When execute resolves the oldest in-flight branch, it produces the registered train_* signals and the misprediction flag. On a misprediction it flushes all younger, wrong-path entries and pulses a front-end flush.

## Interface
- DEPTH, 8, number of in-flight branch entries; power of two, ≥2
- PCW, 7, PC index width (matches predictor PHT index)
- HW, 7, global history width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enq_valid  in  1  front end has a prediction to record
- enq_pc  in  PCW  branch PC index used for the prediction
- enq_history  in  HW  history value used for the prediction
- enq_pred_taken  in  1  predicted direction
- enq_ready  out  1  queue can accept an entry (not full)
- res_valid  in  1  execute resolves the oldest in-flight branch
- res_taken  in  1  actual branch direction
- train_valid  out  1  one-cycle training strobe
- train_taken  out  1  actual direction of the trained branch
- train_mispredicted  out  1  actual direction differed from prediction
- train_pc  out  PCW  PC of the trained branch
- train_history  out  HW  history recorded with the trained branch
- flush  out  1  one-cycle pulse with every mispredicted train strobe
- count  out  $clog2(DEPTH)+1  occupied entries
- underflow  out  1  sticky; set by res_valid while empty

## Operation
- Circular buffer of DEPTH entries {pc, history, pred_taken}, with read pointer, write pointer and count.
- Enqueue is accepted when enq_valid && enq_ready. The entry is written at the write pointer, the pointer advances modulo DEPTH, and count increments.
- enq_ready = (count != DEPTH), derived from registered state only. It does not depend on same-cycle res_valid. Enqueue while full is dropped.
- Resolution takes effect when res_valid && count != 0:
  - The head entry is read.
  - mis = res_taken ^ head.pred_taken.
  - The train_* registers load {1, res_taken, mis, head.pc, head.history}.
  - If not mis: the read pointer advances and count decrements.
  - If mis: the queue is emptied (count←0, write pointer←read pointer) and flush←1.
- Simultaneous accepted enqueue and correct resolution: both happen; count is unchanged.
- Simultaneous accepted enqueue and mispredicted resolution: the enqueued entry is wrong-path and is discarded; count←0.
- res_valid while count==0: no train strobe, no state change except underflow←1.
- underflow clears only on reset.
- No internal FSM beyond pointers and count; count never exceeds DEPTH and never goes negative.

## Timing
- Reset, asynchronous: train_valid, train_taken, train_mispredicted, flush, underflow = 0; train_pc = 0; train_history = 0; count = 0; enq_ready = 1; pointers = 0.
- Resolution to training latency is 1 cycle: res_valid at edge N produces train_valid, train_* and flush high for the cycle after edge N only.
- train_pc, train_history and train_taken hold their values when train_valid = 0.
- An entry enqueued at edge N can be resolved at edge N+1 at the earliest.
- Back-to-back resolutions give one train strobe per cycle.
- Pointer wrap from DEPTH-1 to 0 is seamless.
- An asserted reset mid-stream discards all entries immediately.

## Test plan
- Reset, then enqueue {pc=7'h12, hist=7'h05, pred=1}, then res_valid, res_taken=1 → the next cycle gives train_valid=1, taken=1, mispredicted=0, pc=7'h12, history=7'h05, flush=0; count goes 1→0.
- Enqueue 3 entries with pred={0,0,1}, then resolve the first with res_taken=1 → train_mispredicted=1 and flush=1 for one cycle; count=0; a further res_valid sets underflow=1 with no train_valid.
- Fill to DEPTH=8 → enq_ready=0; a 9th enqueue is dropped; resolving 8 correct branches returns PCs in enqueue order, then count=0.
- Keep 2 entries queued and run 20 cycles of simultaneous enqueue plus correct resolve → count stays 2; pointers wrap past 7; train_pc follows FIFO order.
- Simultaneous enqueue {pc=7'h40} and mispredicted resolve → count=0 afterward; a later res_valid raises underflow; pc 7'h40 never appears on train_pc.
- Assert rst_n=0 mid-stream with 5 entries queued → all outputs return to reset values asynchronously; after release, enq_ready=1 and count=0.
